// File: rtl/pdm_mic_array.sv
// pdm_mic_array: multi-channel PDM microphone front end.
// One shared mic clock; each data line carries two mics, one per clock phase.
// Per channel: boxcar moving sum, decimation to audio rate, gain with saturation.
`timescale 1ns/1ps
module pdm_mic_array #(
   parameter int SAMPLE_DEPTH    = 16,
   parameter int CHANNELS        = 2,
   parameter int WINDOW_LOG2     = 9,
   parameter int INPUT_FREQUENCY = 12000000,
   parameter int FREQUENCY       = 1000000,
   parameter int DECIMATION      = 125
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             enable,
   input  logic [2:0]                       gain,
   output logic                             mic_clk,
   input  logic [CHANNELS/2-1:0]            mic_data,
   output logic [CHANNELS*SAMPLE_DEPTH-1:0] audio,
   output logic                             audio_valid
);

   localparam int HALF   = INPUT_FREQUENCY / (2 * FREQUENCY);
   localparam int PERIOD = 2 * HALF;
   localparam int CNT_W  = $clog2(PERIOD);
   localparam int LINES  = CHANNELS / 2;
   localparam int WIN    = 1 << WINDOW_LOG2;
   localparam int SUM_W  = WINDOW_LOG2 + 2;
   localparam int FILL_W = WINDOW_LOG2 + 1;
   localparam int SHIFT  = (SAMPLE_DEPTH >= SUM_W) ? 0 : SUM_W - SAMPLE_DEPTH;
   localparam int DEC_W  = (DECIMATION > 1) ? $clog2(DECIMATION) : 1;
   localparam int WIDE   = SAMPLE_DEPTH + 8;
   localparam logic signed [WIDE-1:0] SAT_MAX = (WIDE'(1) <<< (SAMPLE_DEPTH - 1)) - WIDE'(1);
   localparam logic signed [WIDE-1:0] SAT_MIN = ~SAT_MAX;

   logic              run;
   logic [CNT_W-1:0]  cnt;
   logic [CNT_W-1:0]  cnt_n;
   logic [LINES-1:0]  sync1;
   logic [LINES-1:0]  sync2;
   logic              cap_even;
   logic              cap_odd;
   logic [DEC_W-1:0]  dec_cnt;
   logic              pend;
   logic [FILL_W-1:0] fill_cnt;
   logic              filled;
   logic              latch;

   // Next phase count: held at 0 while stopped and for the first enabled cycle,
   // so a restart always begins at count 0 with mic_clk high.
   always_comb begin
      cnt_n = '0;
      if (enable && run)
         cnt_n = (cnt == CNT_W'(PERIOD - 1)) ? '0 : cnt + CNT_W'(1);
   end

   // Phase counter and registered mic clock (mic_clk always reflects cnt).
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         run     <= 1'b0;
         cnt     <= '0;
         mic_clk <= 1'b0;
      end else begin
         run     <= enable;
         cnt     <= cnt_n;
         mic_clk <= enable && (cnt_n < CNT_W'(HALF));
      end
   end

   // Two-flop synchroniser for the asynchronous PDM data lines.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1 <= '0;
         sync2 <= '0;
      end else begin
         sync1 <= mic_data;
         sync2 <= sync1;
      end
   end

   assign cap_even = run && (cnt == CNT_W'(HALF - 1));
   assign cap_odd  = run && (cnt == CNT_W'(PERIOD - 1));
   assign filled   = fill_cnt[WINDOW_LOG2];
   assign latch    = pend && filled && enable;

   // Decimation, fill tracking and output strobe; the odd capture closes a period.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dec_cnt     <= '0;
         pend        <= 1'b0;
         fill_cnt    <= '0;
         audio_valid <= 1'b0;
      end else begin
         pend        <= cap_odd && (dec_cnt == DEC_W'(DECIMATION - 1));
         audio_valid <= latch;
         if (cap_odd)
            dec_cnt <= (dec_cnt == DEC_W'(DECIMATION - 1)) ? '0 : dec_cnt + DEC_W'(1);
         if (cap_odd && !filled)
            fill_cnt <= fill_cnt + FILL_W'(1);
      end
   end

   for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
      localparam int LINE = g / 2;
      localparam bit ODD  = (g % 2) == 1;

      logic                           cap;
      logic [WIN-1:0]                 hist;
      logic signed [SUM_W-1:0]        sum;
      logic signed [SUM_W-1:0]        sum_nxt;
      logic signed [SAMPLE_DEPTH-1:0] base;
      logic signed [WIDE-1:0]         wide_v;
      logic [SAMPLE_DEPTH-1:0]        sat;
      logic [SAMPLE_DEPTH-1:0]        out_q;

      assign cap = ODD ? cap_odd : cap_even;

      // Moving-sum update: add the new bit as +/-1, drop the oldest once the window is full.
      always_comb begin
         sum_nxt = sum;
         if (cap) begin
            sum_nxt = sync2[LINE] ? sum + SUM_W'(1) : sum - SUM_W'(1);
            if (filled)
               sum_nxt = hist[WIN-1] ? sum_nxt - SUM_W'(1) : sum_nxt + SUM_W'(1);
         end
      end

      // Window history and running sum.
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            hist <= '0;
            sum  <= '0;
         end else if (cap) begin
            hist <= {hist[WIN-2:0], sync2[LINE]};
            sum  <= sum_nxt;
         end
      end

      // Fit sum to sample width (sign-extend or arithmetic shift), apply gain, saturate.
      always_comb begin
         base   = SAMPLE_DEPTH'(sum >>> SHIFT);
         wide_v = WIDE'(base) <<< gain;
         if (wide_v > SAT_MAX)
            sat = SAT_MAX[SAMPLE_DEPTH-1:0];
         else if (wide_v < SAT_MIN)
            sat = SAT_MIN[SAMPLE_DEPTH-1:0];
         else
            sat = wide_v[SAMPLE_DEPTH-1:0];
      end

      // Output sample register, updated for every channel on the same strobe.
      always_ff @(posedge clk or posedge rst) begin
         if (rst)
            out_q <= '0;
         else if (latch)
            out_q <= sat;
      end

      assign audio[g*SAMPLE_DEPTH +: SAMPLE_DEPTH] = out_q;
   end

endmodule

// File: tb/tb_pdm_mic_array.sv
// Testbench for pdm_mic_array: phase-aware mic model drives the data line,
// a window model pushes expected samples, the monitor pops and compares.
`timescale 1ns/1ps
module tb_pdm_mic_array;

   localparam int SD   = 16;
   localparam int SD8  = 8;
   localparam int CH   = 2;
   localparam int WL   = 4;
   localparam int WIN  = 16;
   localparam int DEC  = 4;
   localparam int PER  = 12;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              enable = 1'b0;
   logic [2:0]        gain = 3'd0;
   logic [0:0]        mic_data = 1'b0;
   logic              mic_clk, mic_clk8;
   logic [CH*SD-1:0]  audio;
   logic [CH*SD8-1:0] audio8;
   logic              audio_valid, audio_valid8;

   always #5 clk = ~clk;

   pdm_mic_array #(
      .SAMPLE_DEPTH(SD), .CHANNELS(CH), .WINDOW_LOG2(WL),
      .INPUT_FREQUENCY(12000000), .FREQUENCY(1000000), .DECIMATION(DEC)
   ) u_dut (
      .clk(clk), .rst(rst), .enable(enable), .gain(gain), .mic_clk(mic_clk),
      .mic_data(mic_data), .audio(audio), .audio_valid(audio_valid)
   );

   pdm_mic_array #(
      .SAMPLE_DEPTH(SD8), .CHANNELS(CH), .WINDOW_LOG2(WL),
      .INPUT_FREQUENCY(12000000), .FREQUENCY(1000000), .DECIMATION(DEC)
   ) u_dut8 (
      .clk(clk), .rst(rst), .enable(enable), .gain(gain), .mic_clk(mic_clk8),
      .mic_data(mic_data), .audio(audio8), .audio_valid(audio_valid8)
   );

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, act, exp);
      end
   endtask

   typedef struct {
      int s0;
      int s1;
      int g;
   } exp_t;

   exp_t sb[$];
   int   cyc = 0;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic int scale(input int s, input int g, input int sd);
      int v, hi, lo;
      v  = s * (1 << g);
      hi = (1 << (sd - 1)) - 1;
      lo = -(1 << (sd - 1));
      if (v > hi) return hi;
      if (v < lo) return lo;
      return v;
   endfunction

   function automatic int wsum(input int q[$]);
      int s = 0;
      foreach (q[i]) s += q[i];
      return s;
   endfunction

   // 0: line high in high phase, low in low phase; 1: alternating per capture; 2: random
   int mode = 0;

   function automatic bit pick(input int m, input int n, input bit is_odd);
      if (m == 0) return !is_odd;
      if (m == 1) return (n % 2) == 0;
      return bit'($urandom_range(1, 0));
   endfunction

   // Mic model: even mic drives while mic_clk is high, odd mic while low.
   initial begin : driver
      int  win0[$];
      int  win1[$];
      int  n0, n1;
      bit  b0, b1, even_pend, odd_pend, prev_mc;
      exp_t e;
      n0 = 0; n1 = 0; b0 = 0; b1 = 0;
      even_pend = 0; odd_pend = 0; prev_mc = 0;
      forever begin
         @(negedge clk);
         if (rst) begin
            win0.delete(); win1.delete(); sb.delete();
            n0 = 0; n1 = 0; even_pend = 0; odd_pend = 0; prev_mc = 0;
         end else begin
            if (mic_clk && !prev_mc) begin
               if (odd_pend) begin
                  win1.push_back(b1 ? 1 : -1);
                  if (win1.size() > WIN) void'(win1.pop_front());
                  n1++;
                  odd_pend = 0;
                  if (n1 >= WIN && (n1 % DEC) == 0) begin
                     e.s0 = wsum(win0);
                     e.s1 = wsum(win1);
                     e.g  = int'(gain);
                     sb.push_back(e);
                  end
               end
               b0 = pick(mode, n0, 1'b0);
               mic_data[0] = b0;
               even_pend = 1;
            end else if (!mic_clk && prev_mc) begin
               if (even_pend) begin
                  win0.push_back(b0 ? 1 : -1);
                  if (win0.size() > WIN) void'(win0.pop_front());
                  n0++;
                  even_pend = 0;
               end
               b1 = pick(mode, n1, 1'b1);
               mic_data[0] = b1;
               odd_pend = 1;
            end
            prev_mc = mic_clk;
         end
      end
   end

   int nvalid = 0;
   int last_v = -1;

   initial begin : monitor
      exp_t e;
      int   a0, a1, c0, c1;
      forever begin
         @(negedge clk);
         if (rst) begin
            last_v = -1;
         end else begin
            if (audio_valid8 != audio_valid) check("valid_sd8", int'(audio_valid8), int'(audio_valid));
            if (mic_clk8 != mic_clk) check("mic_clk_sd8", int'(mic_clk8), int'(mic_clk));
            if (audio_valid) begin
               nvalid++;
               if (last_v >= 0) check("valid_spacing", cyc - last_v, DEC * PER);
               last_v = cyc;
               check("sb_nonempty", int'(sb.size() > 0), 1);
               if (sb.size() > 0) begin
                  e  = sb.pop_front();
                  a0 = $signed(audio[SD-1:0]);
                  a1 = $signed(audio[2*SD-1:SD]);
                  c0 = $signed(audio8[SD8-1:0]);
                  c1 = $signed(audio8[2*SD8-1:SD8]);
                  check("ch0", a0, scale(e.s0, e.g, SD));
                  check("ch1", a1, scale(e.s1, e.g, SD));
                  check("ch0_sd8", c0, scale(e.s0, e.g, SD8));
                  check("ch1_sd8", c1, scale(e.s1, e.g, SD8));
               end
            end
            if (!enable) last_v = -1;
         end
      end
   end

   task automatic wait_valids(input int target, input int budget);
      int k = 0;
      while (nvalid < target && k < budget) begin
         @(negedge clk);
         k++;
      end
      check("valid_timeout", int'(nvalid >= target), 1);
   endtask

   initial begin : watchdog
      #1000000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin : stim
      int hi, lo, k, base, highs, t0;
      rst = 1; enable = 0; gain = 0; mode = 0;
      repeat (4) @(negedge clk);
      check("rst_mic_clk", int'(mic_clk), 0);
      check("rst_audio_zero", int'(audio == '0), 1);
      check("rst_valid", int'(audio_valid), 0);

      rst = 0; enable = 1;
      @(negedge clk);
      check("first_high", int'(mic_clk), 1);
      hi = 0;
      while (mic_clk == 1'b1 && hi < 40) begin hi++; @(negedge clk); end
      lo = 0;
      while (mic_clk == 1'b0 && lo < 40) begin lo++; @(negedge clk); end
      check("high_cycles", hi, PER / 2);
      check("low_cycles", lo, PER / 2);

      // DC levels, then gain/saturation, balanced, random
      wait_valids(3, 2000);
      gain = 3'd7;
      wait_valids(nvalid + 2, 300);
      mode = 1; gain = 3'd0;
      wait_valids(nvalid + 6, 600);
      mode = 2; gain = 3'd3;
      wait_valids(nvalid + 4, 400);

      // enable low stops clock and output
      wait_valids(nvalid + 1, 100);
      @(negedge clk);
      enable = 0;
      base = nvalid;
      @(negedge clk);
      check("disable_mic_clk", int'(mic_clk), 0);
      highs = 0;
      repeat (100) begin @(negedge clk); highs += int'(mic_clk); end
      check("disabled_no_clk", highs, 0);
      check("disabled_no_valid", nvalid - base, 0);
      check("sb_drained", sb.size(), 0);

      rst = 1; enable = 1; mode = 0; gain = 0;
      repeat (3) @(negedge clk);
      rst = 0;
      wait_valids(nvalid + 2, 2000);

      // reset mid-period
      k = 0;
      while (mic_clk && k < 20) begin @(negedge clk); k++; end
      k = 0;
      while (!mic_clk && k < 20) begin @(negedge clk); k++; end
      @(negedge clk);
      @(negedge clk);
      rst = 1;
      #1;
      check("midrst_mic_clk", int'(mic_clk), 0);
      check("midrst_audio_zero", int'(audio == '0), 1);
      check("midrst_valid", int'(audio_valid), 0);
      repeat (3) @(negedge clk);
      rst = 0;
      t0 = cyc;
      base = nvalid;
      wait_valids(base + 1, 400);
      check("refill_time", int'((last_v - t0) >= WIN * PER && (last_v - t0) <= WIN * PER + 4), 1);
      wait_valids(nvalid + 2, 300);
      check("sb_final", sb.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/pdm_mic_array.md
Name: pdm_mic_array

Overview:
- Multi-channel PDM microphone front end; successor to the single-mic boxcar decimator.
- Drives one shared mic clock. Each data line carries two mics, split across the two clock phases.
- Per channel: a moving-sum (boxcar) filter over a configurable window, decimation to the audio rate, runtime gain with saturation.
- Outputs all channels together with a valid strobe to the downstream audio/LED-reactive logic.

Parameters:
- SAMPLE_DEPTH, 16, output sample width per channel (signed).
- CHANNELS, 2, number of mic channels; must be even, 2..8.
- WINDOW_LOG2, 9, boxcar window length = 2^WINDOW_LOG2 PDM bits per channel.
- INPUT_FREQUENCY, 12000000, clk frequency in Hz.
- FREQUENCY, 1000000, mic_clk frequency in Hz. HALF = INPUT_FREQUENCY/(2*FREQUENCY) must be >= 4.
- DECIMATION, 125, mic_clk periods per output sample.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- enable  in  1  run control; low stops mic_clk and output.
- gain  in  3  left-shift applied to filtered sample (0..7).
- mic_clk  out  1  PDM clock to all mics.
- mic_data  in  CHANNELS/2  PDM data lines, asynchronous to clk.
- audio  out  CHANNELS*SAMPLE_DEPTH  channel k at bits [k*SAMPLE_DEPTH +: SAMPLE_DEPTH], signed.
- audio_valid  out  1  one-cycle strobe; audio updated this cycle.

Behaviour:
- Reset (async assert, sync release) values:
  - mic_clk=0, audio=0, audio_valid=0.
  - Divider, decimation counter and fill counter cleared; all moving sums cleared.
- Clock generation:
  - Phase counter runs 0..2*HALF-1 while enable=1.
  - mic_clk=1 for counts 0..HALF-1, 0 otherwise.
  - enable=0: counter held at 0, mic_clk=0, no captures, no audio_valid. Filter state is retained.
  - enable rising resumes from count 0.
- Capture:
  - mic_data passes through a 2-flop synchroniser.
  - Line j, channel 2j: captured at count HALF-1 (last cycle of the high phase).
  - Line j, channel 2j+1: captured at count 2*HALF-1 (last cycle of the low phase).
- Filter, per channel:
  - Bit mapped to +1 (1) or -1 (0).
  - A 2^WINDOW_LOG2-deep 1-bit history (RAM or shift register) holds the last window bits.
  - On each capture: sum <= sum + new - oldest. Oldest is the bit written 2^WINDOW_LOG2 captures earlier.
  - Sum width: WINDOW_LOG2+2 bits signed, no overflow possible.
- Fill:
  - Until 2^WINDOW_LOG2 captures have occurred per channel since reset, the subtraction is skipped.
  - audio_valid is suppressed during fill.
  - Fill is not restarted by enable toggling.
- Scaling:
  - If SAMPLE_DEPTH >= WINDOW_LOG2+2, the sum is sign-extended; otherwise it is arithmetically right-shifted to SAMPLE_DEPTH bits.
  - Then shifted left by gain and saturated to [-2^(SAMPLE_DEPTH-1), 2^(SAMPLE_DEPTH-1)-1].
- Decimation:
  - The counter increments at count 2*HALF-1.
  - On reaching DECIMATION-1 it wraps to 0, and on the next cycle all channels are latched into audio and audio_valid pulses for one cycle.
  - Latency: 1 clk after the final odd-channel capture of the period.
  - All channels are always updated in the same cycle.
- Reset mid-operation: immediate return to reset values; any in-flight sample is discarded; fill restarts.

Test Plan (INPUT_FREQUENCY=12000000, FREQUENCY=1000000 so HALF=6, WINDOW_LOG2=4, DECIMATION=4, CHANNELS=2, SAMPLE_DEPTH=16):
- Clocking: enable=1 -> mic_clk period 12 clk, high 6 / low 6, first high at count 0; enable=0 -> mic_clk held 0 within 1 clk, audio_valid never asserts.
- DC levels: line0 driven 1 during high phase and 0 during low phase, gain=0 -> after fill (16 periods), every audio_valid gives ch0=+16, ch1=-16, one strobe per 48 clk.
- Balanced input: alternating 1,0 per capture on both channels -> ch0 and ch1 each within ±1 of 0 on every valid.
- Gain/saturation: ch0 all ones, gain=7 with SAMPLE_DEPTH=8 -> ch0=127; ch1 all zeros -> -128.
- Fill gating: first audio_valid only after 16 mic_clk periods; strobes thereafter exactly every 4 periods.
- Reset mid-run: assert rst for 3 clk mid-period -> audio=0, mic_clk=0 immediately; refill of 16 periods required before the next valid.
